// File: rtl/conv_edge_param.sv
// 3x3 dual-kernel (Gx/Gy) convolution engine with runtime-programmable kernels,
// thresholded-edge or saturated-magnitude output, and a single global stall.
module conv_edge_param #(
  parameter int PIXEL_W = 8,
  parameter int COEF_W  = 8
) (
  input  logic                                 i_clk,
  input  logic                                 i_rstn,
  input  logic [9*PIXEL_W-1:0]                 i_pixel_data,
  input  logic                                 i_pixel_data_valid,
  output logic                                 o_pixel_data_ready,
  input  logic [1:0]                           i_mode,
  input  logic [2*(PIXEL_W+COEF_W+4):0]        i_threshold,
  input  logic                                 i_coef_wr,
  input  logic                                 i_coef_sel,
  input  logic [3:0]                           i_coef_addr,
  input  logic [COEF_W-1:0]                    i_coef_data,
  output logic [PIXEL_W-1:0]                   o_convolved_data,
  output logic                                 o_convolved_data_valid,
  input  logic                                 i_convolved_data_ready
);

  localparam int SUM_W = PIXEL_W + COEF_W + 4;
  localparam int MAG_W = 2 * SUM_W + 1;
  localparam int SOBEL_GX [9] = '{1, 0, -1, 2, 0, -2, 1, 0, -1};
  localparam int SOBEL_GY [9] = '{1, 2, 1, 0, 0, 0, -1, -2, -1};
  localparam logic [MAG_W-1:0] PIX_MAX = {{(MAG_W-PIXEL_W){1'b0}}, {PIXEL_W{1'b1}}};

  logic signed [COEF_W-1:0] gx_coef [9];
  logic signed [COEF_W-1:0] gy_coef [9];

  logic advance;
  logic accept;

  logic signed [SUM_W-1:0] gx_prod [9];
  logic signed [SUM_W-1:0] gy_prod [9];

  // Stage 1: per-tap products
  logic                    s1_valid;
  logic [1:0]              s1_mode;
  logic [MAG_W-1:0]        s1_thr;
  logic signed [SUM_W-1:0] s1_gx [9];
  logic signed [SUM_W-1:0] s1_gy [9];

  // Stage 2: kernel sums
  logic                    s2_valid;
  logic [1:0]              s2_mode;
  logic [MAG_W-1:0]        s2_thr;
  logic signed [SUM_W-1:0] s2_gx;
  logic signed [SUM_W-1:0] s2_gy;
  logic signed [SUM_W-1:0] gx_sum;
  logic signed [SUM_W-1:0] gy_sum;

  // Stage 3: magnitude
  logic                    s3_valid;
  logic [1:0]              s3_mode;
  logic [MAG_W-1:0]        s3_thr;
  logic [MAG_W-1:0]        s3_mag;
  logic [SUM_W-1:0]        abs_gx;
  logic [SUM_W-1:0]        abs_gy;
  logic signed [MAG_W-1:0] sq_sum;
  logic [MAG_W-1:0]        mag;

  // Stage 4: compare result, final select happens on the output register
  logic                    s4_valid;
  logic                    s4_thr_mode;
  logic                    s4_gt;
  logic [PIXEL_W-1:0]      s4_low;
  logic                    cmp_gt;

  assign advance            = i_convolved_data_ready || !o_convolved_data_valid;
  assign accept             = i_pixel_data_valid && advance;
  assign o_pixel_data_ready = advance;

  // Products use the pre-write bank, so a window accepted on a write edge sees old taps.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      for (int unsigned i = 0; i < 9; i++) begin
        gx_coef[i] <= COEF_W'(SOBEL_GX[i]);
        gy_coef[i] <= COEF_W'(SOBEL_GY[i]);
      end
    end else if (i_coef_wr) begin
      for (int unsigned i = 0; i < 9; i++) begin
        if (i_coef_addr == 4'(i)) begin
          if (i_coef_sel) gy_coef[i] <= i_coef_data;
          else            gx_coef[i] <= i_coef_data;
        end
      end
    end
  end

  always_comb begin
    logic signed [PIXEL_W:0] tap;
    tap = '0;
    for (int unsigned i = 0; i < 9; i++) begin
      tap        = {1'b0, i_pixel_data[i*PIXEL_W +: PIXEL_W]};
      gx_prod[i] = SUM_W'(gx_coef[i]) * SUM_W'(tap);
      gy_prod[i] = SUM_W'(gy_coef[i]) * SUM_W'(tap);
    end
  end

  always_comb begin
    gx_sum = '0;
    gy_sum = '0;
    for (int unsigned i = 0; i < 9; i++) begin
      gx_sum = gx_sum + s1_gx[i];
      gy_sum = gy_sum + s1_gy[i];
    end
  end

  always_comb begin
    abs_gx = s2_gx[SUM_W-1] ? $unsigned(-s2_gx) : $unsigned(s2_gx);
    abs_gy = s2_gy[SUM_W-1] ? $unsigned(-s2_gy) : $unsigned(s2_gy);
    sq_sum = MAG_W'(s2_gx) * MAG_W'(s2_gx) + MAG_W'(s2_gy) * MAG_W'(s2_gy);
    case (s2_mode)
      2'b00:        mag = $unsigned(sq_sum);
      2'b01, 2'b10: mag = MAG_W'(abs_gx) + MAG_W'(abs_gy);
      default:      mag = MAG_W'(abs_gx);
    endcase
  end

  always_comb begin
    cmp_gt = s3_mode[1] ? (s3_mag > PIX_MAX) : (s3_mag > s3_thr);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      s1_valid               <= 1'b0;
      s2_valid               <= 1'b0;
      s3_valid               <= 1'b0;
      s4_valid               <= 1'b0;
      o_convolved_data_valid <= 1'b0;
      o_convolved_data       <= '0;
      s1_mode                <= '0;
      s2_mode                <= '0;
      s3_mode                <= '0;
      s1_thr                 <= '0;
      s2_thr                 <= '0;
      s3_thr                 <= '0;
      s4_thr_mode            <= 1'b0;
    end else if (advance) begin
      s1_valid <= accept;
      if (accept) begin
        s1_mode <= i_mode;
        s1_thr  <= i_threshold;
      end
      s2_valid               <= s1_valid;
      s2_mode                <= s1_mode;
      s2_thr                 <= s1_thr;
      s3_valid               <= s2_valid;
      s3_mode                <= s2_mode;
      s3_thr                 <= s2_thr;
      s4_valid               <= s3_valid;
      s4_thr_mode            <= !s3_mode[1];
      o_convolved_data_valid <= s4_valid;
      o_convolved_data       <= s4_gt ? '1 : (s4_thr_mode ? '0 : s4_low);
    end
  end

  always_ff @(posedge i_clk) begin
    if (advance) begin
      for (int unsigned i = 0; i < 9; i++) begin
        s1_gx[i] <= gx_prod[i];
        s1_gy[i] <= gy_prod[i];
      end
      s2_gx  <= gx_sum;
      s2_gy  <= gy_sum;
      s3_mag <= mag;
      s4_gt  <= cmp_gt;
      s4_low <= s3_mag[PIXEL_W-1:0];
    end
  end

endmodule

// File: tb/tb_conv_edge_param.sv
// Directed bench for conv_edge_param: arithmetic reference model plus a
// per-cycle scoreboard, and literal expectations for the key windows.
module tb_conv_edge_param;

  localparam int PW    = 8;
  localparam int CW    = 8;
  localparam int MAG_W = 2 * (PW + CW + 4) + 1;

  logic              clk;
  logic              rstn;
  logic [9*PW-1:0]   pdata;
  logic              pvalid;
  logic              pready;
  logic [1:0]        pmode;
  logic [MAG_W-1:0]  pthr;
  logic              cwr;
  logic              csel;
  logic [3:0]        caddr;
  logic [CW-1:0]     cdata;
  logic [PW-1:0]     odata;
  logic              ovalid;
  logic              cready;

  conv_edge_param #(.PIXEL_W(PW), .COEF_W(CW)) dut (
    .i_clk                  (clk),
    .i_rstn                 (rstn),
    .i_pixel_data           (pdata),
    .i_pixel_data_valid     (pvalid),
    .o_pixel_data_ready     (pready),
    .i_mode                 (pmode),
    .i_threshold            (pthr),
    .i_coef_wr              (cwr),
    .i_coef_sel             (csel),
    .i_coef_addr            (caddr),
    .i_coef_data            (cdata),
    .o_convolved_data       (odata),
    .o_convolved_data_valid (ovalid),
    .i_convolved_data_ready (cready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int last_acc_edge = 0;
  int delivered = 0;
  int stall_cycles = 0;

  int mgx [9];
  int mgy [9];
  logic [7:0] expq [$];
  logic       stall_prev = 1'b0;
  logic [7:0] stall_data = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    int sx [9] = '{1, 0, -1, 2, 0, -2, 1, 0, -1};
    int sy [9] = '{1, 2, 1, 0, 0, 0, -1, -2, -1};
    for (int i = 0; i < 9; i++) begin
      mgx[i] = sx[i];
      mgy[i] = sy[i];
    end
  endfunction

  function automatic logic [7:0] model_px(input logic [71:0] w, input logic [1:0] m,
                                          input logic [MAG_W-1:0] t);
    longint gx, gy, ax, ay, mag, p;
    gx = 0;
    gy = 0;
    for (int i = 0; i < 9; i++) begin
      p  = longint'(w[i*8 +: 8]);
      gx = gx + mgx[i] * p;
      gy = gy + mgy[i] * p;
    end
    ax = (gx < 0) ? -gx : gx;
    ay = (gy < 0) ? -gy : gy;
    case (m)
      2'd0:    mag = gx * gx + gy * gy;
      2'd1,
      2'd2:    mag = ax + ay;
      default: mag = ax;
    endcase
    if (m < 2'd2) return (mag > longint'(t)) ? 8'hFF : 8'h00;
    return (mag > 255) ? 8'hFF : mag[7:0];
  endfunction

  always @(posedge clk) cyc++;

  // Scoreboard: everything is sampled on the falling edge, i.e. the values the
  // next rising edge will act on.
  always @(negedge clk) begin
    if (rstn) begin
      chk("ready_rule", {63'd0, pready}, {63'd0, (cready || !ovalid)});
      if (stall_prev) begin
        chk("stall_valid_hold", {63'd0, ovalid}, 64'd1);
        chk("stall_data_hold", {56'd0, odata}, {56'd0, stall_data});
      end
      if (ovalid) begin
        n_checks++;
        if (expq.size() == 0) begin
          n_errors++;
          $display("FAIL spurious_output: got valid data %0h expected no output", odata);
        end else if (cready) begin
          chk("stream_data", {56'd0, odata}, {56'd0, expq.pop_front()});
          delivered++;
        end
      end
      stall_prev = ovalid && !cready;
      stall_data = odata;
      if (ovalid && !cready) stall_cycles++;
      if (pvalid && (cready || !ovalid)) begin
        expq.push_back(model_px(pdata, pmode, pthr));
        last_acc_edge = cyc + 1;
      end
      if (cwr && caddr < 4'd9) begin
        if (csel) mgy[caddr] = int'($signed(cdata));
        else      mgx[caddr] = int'($signed(cdata));
      end
    end else begin
      expq.delete();
      model_reset();
      stall_prev = 1'b0;
    end
  end

  task automatic present(input logic [71:0] w, input logic [1:0] m, input logic [MAG_W-1:0] t);
    int k;
    pdata  = w;
    pmode  = m;
    pthr   = t;
    pvalid = 1'b1;
    k = 0;
    @(negedge clk);
    while (!pready && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (!pready) begin
      n_checks++;
      n_errors++;
      $display("FAIL accept_timeout: got ready 0 expected 1");
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_win(input logic [71:0] w, input logic [1:0] m, input logic [MAG_W-1:0] t);
    @(posedge clk);
    #1;
    present(w, m, t);
    pvalid = 1'b0;
  endtask

  task automatic expect_out(input string name, input logic [7:0] exp, output int out_cyc);
    int k;
    k = 0;
    @(negedge clk);
    while (!ovalid && k < 20) begin
      @(negedge clk);
      k++;
    end
    out_cyc = cyc;
    if (!ovalid) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s_timeout: got no valid output expected %0h", name, exp);
    end else begin
      chk(name, {56'd0, odata}, {56'd0, exp});
    end
  endtask

  task automatic wr_coef(input logic s, input logic [3:0] a, input logic [7:0] d);
    @(posedge clk);
    #1;
    cwr   = 1'b1;
    csel  = s;
    caddr = a;
    cdata = d;
    @(posedge clk);
    #1;
    cwr = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [71:0] w_col, w_100, w_t3, w_t1, w_t2, w_20, w;
    int oc, base_del, base_stall, vcount;

    model_reset();
    rstn = 1'b0; pvalid = 1'b0; pdata = '0; pmode = '0; pthr = '0;
    cwr = 1'b0; csel = 1'b0; caddr = '0; cdata = '0; cready = 1'b1;

    w_col = '0; w_col[0 +: 8] = 8'd255; w_col[24 +: 8] = 8'd255; w_col[48 +: 8] = 8'd255;
    w_100 = {9{8'd100}};
    w_t3  = '0; w_t3[24 +: 8] = 8'd30;
    w_t1  = '0; w_t1[8 +: 8]  = 8'd50;
    w_t2  = '0; w_t2[16 +: 8] = 8'd40;
    w_20  = {9{8'd20}};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_valid", {63'd0, ovalid}, 64'd0);
    chk("reset_data", {56'd0, odata}, 64'd0);
    chk("reset_ready", {63'd0, pready}, 64'd1);
    @(posedge clk);
    #1 rstn = 1'b1;

    send_win(w_col, 2'd0, MAG_W'(4000));
    expect_out("m0_col255", 8'hFF, oc);
    chk("latency", 64'(oc - last_acc_edge), 64'd4);
    send_win(w_100, 2'd0, MAG_W'(4000));
    expect_out("m0_flat", 8'h00, oc);

    send_win(w_t3, 2'd0, MAG_W'(3600));
    expect_out("m0_thr_eq", 8'h00, oc);
    send_win(w_t3, 2'd0, MAG_W'(3599));
    expect_out("m0_thr_below", 8'hFF, oc);
    send_win(w_t3, 2'd1, MAG_W'(60));
    expect_out("m1_thr_eq", 8'h00, oc);
    send_win(w_t3, 2'd1, MAG_W'(59));
    expect_out("m1_thr_below", 8'hFF, oc);

    send_win(w_col, 2'd2, '0);
    expect_out("m2_sat", 8'hFF, oc);
    send_win(w_t3, 2'd2, '0);
    expect_out("m2_60", 8'h3C, oc);
    send_win(w_t1, 2'd2, '0);
    expect_out("m2_gy100", 8'h64, oc);
    send_win(w_t1, 2'd3, '0);
    expect_out("m3_gx0", 8'h00, oc);
    send_win(w_t2, 2'd3, '0);
    expect_out("m3_neg", 8'h28, oc);
    send_win(w_t2, 2'd2, '0);
    expect_out("m2_neg", 8'h50, oc);

    // Backpressure: 8 back-to-back windows, ready dropped for 5 cycles.
    repeat (3) @(posedge clk);
    base_del   = delivered;
    base_stall = stall_cycles;
    @(posedge clk);
    #1;
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          w = '0;
          w[24 +: 8] = 8'(10 * (i + 1));
          w[8 +: 8]  = 8'(5 * i);
          present(w, 2'd2, '0);
        end
        pvalid = 1'b0;
      end
      begin
        repeat (6) @(posedge clk);
        #1 cready = 1'b0;
        repeat (5) @(posedge clk);
        #1 cready = 1'b1;
      end
    join
    repeat (15) @(negedge clk);
    chk("bp_delivered", 64'(delivered - base_del), 64'd8);
    chk("bp_stall_cycles", 64'(stall_cycles - base_stall), 64'd5);
    chk("bp_queue_empty", 64'(expq.size()), 64'd0);

    // Reprogram: Gy all 0, Gx all 1; last Gx write coincides with a window.
    for (int i = 0; i < 9; i++) wr_coef(1'b1, 4'(i), 8'd0);
    for (int i = 0; i < 8; i++) wr_coef(1'b0, 4'(i), 8'd1);
    @(posedge clk);
    #1;
    cwr = 1'b1; csel = 1'b0; caddr = 4'd8; cdata = 8'd1;
    pdata = w_20; pmode = 2'd2; pthr = '0; pvalid = 1'b1;
    @(posedge clk);
    #1;
    cwr = 1'b0; pvalid = 1'b0;
    expect_out("same_cycle_old_coef", 8'h8C, oc);
    send_win(w_20, 2'd2, '0);
    expect_out("reprog_sum", 8'hB4, oc);
    wr_coef(1'b0, 4'd9, 8'd5);
    send_win(w_20, 2'd2, '0);
    expect_out("addr9_noop", 8'hB4, oc);

    // Reset with three windows in flight and a window offered during reset.
    repeat (3) @(posedge clk);
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) present(w_20, 2'd2, '0);
    rstn = 1'b0;
    pdata = w_col;
    pvalid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    pvalid = 1'b0;
    vcount = 0;
    repeat (8) begin
      @(negedge clk);
      if (ovalid) vcount++;
    end
    chk("reset_flush", 64'(vcount), 64'd0);
    send_win(w_t3, 2'd2, '0);
    expect_out("post_reset_sobel", 8'h3C, oc);

    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/conv_edge_param.md
# conv_edge_param

Parametrised 3x3 dual-kernel edge/filter engine for the spatial-filter pixel pipeline. It accepts a 3x3 pixel window per cycle from the line-buffer stage and convolves it with two runtime-programmable signed kernels, Gx and Gy. It then produces, per window, either a thresholded binary edge pixel or a saturated magnitude pixel. It succeeds the fixed 8-bit Sobel/threshold block and adds generic widths, kernel reprogramming, a runtime threshold, output modes, synchronous reset and output backpressure.

## Interface
Parameters:
- PIXEL_W, 8, unsigned pixel width.
- COEF_W, 8, signed coefficient width.
- Derived: SUM_W = PIXEL_W+COEF_W+4 (signed kernel sum); MAG_W = 2*SUM_W+1 (threshold/magnitude width).

Ports:
- i_clk  in  1  single clock; all logic on its rising edge.
- i_rstn  in  1  reset, synchronous, active-low.
- i_pixel_data  in  9*PIXEL_W  window. Tap i is at [i*PIXEL_W +: PIXEL_W], row-major, i=0 top-left, unsigned.
- i_pixel_data_valid  in  1  window valid.
- o_pixel_data_ready  out  1  window accepted when valid&&ready.
- i_mode  in  2  00: sum-of-squares threshold; 01: |Gx|+|Gy| threshold; 10: |Gx|+|Gy| saturated; 11: |Gx| saturated.
- i_threshold  in  MAG_W  unsigned threshold for modes 00/01.
- i_coef_wr  in  1  coefficient write strobe.
- i_coef_sel  in  1  0 = Gx, 1 = Gy.
- i_coef_addr  in  4  tap index 0..8; 9..15 ignored.
- i_coef_data  in  COEF_W  signed coefficient.
- o_convolved_data  out  PIXEL_W  result pixel.
- o_convolved_data_valid  out  1  result valid.
- i_convolved_data_ready  in  1  downstream accepts when valid&&ready.

## Operation
- Four-stage pipeline with one valid bit per stage. Global advance enable: en = i_convolved_data_ready || !o_convolved_data_valid. o_pixel_data_ready = en. When en=0, all stages hold. Interior bubbles are not compressed.
- i_mode and i_threshold are captured into S1 with each accepted window and travel with it. Changing them never affects in-flight data.
- S1 (multiply): for each tap, signed(coef) * signed({1'b0,pixel}) for Gx and Gy, sign-extended to SUM_W.
- S2 (sum): Gx = sum of 9 Gx products and Gy = sum of 9 Gy products, both signed SUM_W. The sum is exact and has no overflow at these widths.
- S3 (magnitude):
  - Mode 00: M = Gx²+Gy², unsigned MAG_W.
  - Modes 01/10: M = |Gx|+|Gy|.
  - Mode 11: M = |Gx|.
  - All results are zero-extended to MAG_W.
- S4 (output):
  - Modes 00/01: out = (M > i_threshold) ? all-ones : 0. The compare is strictly greater.
  - Modes 10/11: out = (M > 2^PIXEL_W-1) ? all-ones : M[PIXEL_W-1:0].
- Coefficient bank: 18 registers.
  - A write lands at the clock edge where i_coef_wr=1 and is visible to windows accepted from the next cycle onward. A window accepted in the same cycle as the write uses the old value.
  - Writes are allowed while stalled.
  - Addresses 9..15 are no-ops.
- Reset (i_rstn=0 at an edge):
  - All stage valids and o_convolved_data_valid clear to 0; o_convolved_data clears to 0; in-flight windows are discarded.
  - Coefficients reload Gx = {1,0,-1,2,0,-2,1,0,-1} and Gy = {1,2,1,0,0,0,-1,-2,-1}.
  - Captured mode and threshold clear to 0.
  - o_pixel_data_ready reads 1 during and after reset, because valid is 0. Inputs presented while i_rstn=0 are not accepted.

## Timing
- Latency: a window accepted at edge N appears on o_convolved_data with valid=1 after edge N+4, provided en=1 throughout.
- Throughput: one window per cycle while downstream is ready.
- Stall: while o_convolved_data_valid=1 and i_convolved_data_ready=0, the outputs and all stages hold stable and o_pixel_data_ready=0. Release resumes with no loss or duplication, in order.
- Simultaneous events: a coefficient write together with a stall is accepted. Reset overrides stall and writes.

## Test plan
- Reset, then mode 00, threshold 4000. Window with taps 0,3,6=255 and others 0 → Gx=1020, Gy=0 → 0xFF exactly 4 cycles after acceptance. Window all 100 → 0x00.
- Threshold boundary, mode 00. Tap 3=30, others 0 → M=3600. Threshold 3600 → 0x00; threshold 3599 → 0xFF.
- Mode 10, same 255-column window → |Gx|=1020 saturates to 0xFF. Tap 3=30 → 60 (0x3C).
- Reprogram: Gx all 1, Gy all 0, mode 10. Window all 20 → 180 (0xB4). A window accepted in the same cycle as the final write still uses the old coefficient.
- Backpressure: stream 8 distinct windows, drop i_convolved_data_ready for 5 cycles mid-stream → all 8 results delivered once, in order, with the output stable while stalled.
- Reset mid-stream with 3 windows in flight → no valid output afterwards, Sobel coefficients restored; the next window produces the expected Sobel result.
